y86_stage_sequencer: RTL and testbench

Sequential-processor controller that drives the Y86 stage blocks (fetch, decode, execute, memory, writeback, PC update) through one instruction at a time. It issues a one-cycle start strobe per stage and waits for that stage's completion strobe. It skips stages that the current icode does not need, and tracks processor status (AOK/HLT/ADR/INS). A watchdog traps stages that never complete. It sits above the stage modules and replaces free-running flag chaining between them.

---
 rtl/y86_pkg.sv | 51 +++++
 rtl/y86_stage_watchdog.sv | 39 +++
 rtl/y86_stage_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_y86_stage_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 sequencing definitions: controller states, status codes, icodes
// and the per-icode stage-usage helpers used by the sequencer and stage blocks.
package y86_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_PCUPD  = 4'd6,
        ST_HALT   = 4'd7,
        ST_FAULT  = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Instructions that touch data memory.
    function automatic logic needs_mem(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

    // Instructions that write a register back.
    function automatic logic needs_wb(input logic [3:0] ic);
        return !(ic inside {I_NOP, I_RMMOVQ, I_JXX});
    endfunction

    function automatic logic is_stage(input state_e s);
        return s inside {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_PCUPD};
    endfunction

endpackage

// File: rtl/y86_stage_watchdog.sv
// Counts cycles since the current stage was entered and flags expiry once the
// count reaches TIMEOUT without the stage having completed.
module y86_stage_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: every path assigns cnt_d, the hold value first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/y86_stage_sequencer.sv
// Sequential Y86 controller: walks one instruction at a time through the stage
// blocks with go/done handshakes, skips unused stages and tracks status.
module y86_stage_sequencer
    import y86_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             wb_done,
    input  logic             pc_done,
    output logic             fetch_go,
    output logic             decode_go,
    output logic             exec_go,
    output logic             mem_go,
    output logic             wb_go,
    output logic             pc_go,
    output logic [3:0]       stage,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    stat_e            stat_q, stat_d;
    logic             entry_q, entry_d;
    logic [3:0]       icode_q, icode_d;
    logic             step_mode_q, step_mode_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    logic in_stage;
    logic waiting;
    logic stage_done;
    logic retire;
    logic wd_expired;

    assign in_stage = is_stage(state_q);
    // The go cycle itself never accepts a done strobe.
    assign waiting  = in_stage && !entry_q;

    always_comb begin
        stage_done = 1'b0;
        unique case (state_q)
            ST_FETCH:  stage_done = fetch_done;
            ST_DECODE: stage_done = decode_done;
            ST_EXEC:   stage_done = exec_done;
            ST_MEM:    stage_done = mem_done;
            ST_WB:     stage_done = wb_done;
            ST_PCUPD:  stage_done = pc_done;
            default:   stage_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stat_d      = stat_q;
        icode_d     = icode_q;
        step_mode_d = step_mode_q;
        retire      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (run || step) begin
                state_d     = ST_FETCH;
                step_mode_d = !run;
            end
        end else if (waiting) begin
            if (wd_expired) begin
                state_d = ST_FAULT;
            end else if (stage_done) begin
                unique case (state_q)
                    ST_FETCH: begin
                        if (imem_error) begin
                            state_d = ST_HALT;
                            stat_d  = STAT_ADR;
                        end else if (!instr_valid) begin
                            state_d = ST_HALT;
                            stat_d  = STAT_INS;
                        end else if (icode == I_HALT) begin
                            state_d = ST_HALT;
                            stat_d  = STAT_HLT;
                        end else begin
                            state_d = ST_DECODE;
                            icode_d = icode;
                        end
                    end
                    ST_DECODE: state_d = ST_EXEC;
                    ST_EXEC: begin
                        if (needs_mem(icode_q)) begin
                            state_d = ST_MEM;
                        end else if (needs_wb(icode_q)) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_PCUPD;
                        end
                    end
                    ST_MEM: begin
                        if (dmem_error) begin
                            state_d = ST_HALT;
                            stat_d  = STAT_ADR;
                        end else if (needs_wb(icode_q)) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_PCUPD;
                        end
                    end
                    ST_WB: state_d = ST_PCUPD;
                    ST_PCUPD: begin
                        retire  = 1'b1;
                        state_d = (run && !step_mode_q) ? ST_FETCH : ST_IDLE;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // No stage ever transitions to itself, so a change of state marks an entry.
    assign entry_d = is_stage(state_d) && (state_d != state_q);
    assign fault_d = fault_q || (state_d == ST_FAULT);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (in_stage && !(&cycle_cnt_q)) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (retire && !(&instr_cnt_q)) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stat_q      <= STAT_AOK;
            entry_q     <= 1'b0;
            icode_q     <= 4'h0;
            step_mode_q <= 1'b0;
            fault_q     <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stat_q      <= stat_d;
            entry_q     <= entry_d;
            icode_q     <= icode_d;
            step_mode_q <= step_mode_d;
            fault_q     <= fault_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    y86_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (entry_d),
        .enable_i  (in_stage),
        .expired_o (wd_expired)
    );

    // NOTE: go strobes decode only flops, so asserting reset drops them at once.
    assign fetch_go  = entry_q && (state_q == ST_FETCH);
    assign decode_go = entry_q && (state_q == ST_DECODE);
    assign exec_go   = entry_q && (state_q == ST_EXEC);
    assign mem_go    = entry_q && (state_q == ST_MEM);
    assign wb_go     = entry_q && (state_q == ST_WB);
    assign pc_go     = entry_q && (state_q == ST_PCUPD);

    assign stage     = state_q;
    assign stat      = stat_q;
    assign busy      = in_stage;
    assign fault     = fault_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Self-checking bench: a responder plays the stage blocks with random latency,
// and expected go sequences / counters come from the instruction-level rules.
module tb_y86_stage_sequencer;
    import y86_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, step = 1'b0;
    logic [3:0] icode = 4'h0;
    logic instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0;
    logic fetch_done = 1'b0, decode_done = 1'b0, exec_done = 1'b0;
    logic mem_done = 1'b0, wb_done = 1'b0, pc_done = 1'b0;
    logic fetch_go, decode_go, exec_go, mem_go, wb_go, pc_go;
    logic [3:0] stage;
    logic [2:0] stat;
    logic busy, fault;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;

    y86_stage_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
        .fetch_done(fetch_done), .decode_done(decode_done), .exec_done(exec_done),
        .mem_done(mem_done), .wb_done(wb_done), .pc_done(pc_done),
        .fetch_go(fetch_go), .decode_go(decode_go), .exec_go(exec_go),
        .mem_go(mem_go), .wb_go(wb_go), .pc_go(pc_go),
        .stage(stage), .stat(stat), .busy(busy), .fault(fault),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Stage indices: 0 fetch, 1 decode, 2 exec, 3 mem, 4 wb, 5 pc update.
    int         obs_q[$];
    int         exp_q[$];
    logic [3:0] icq[$];
    int         rsp_cycles = 0;

    int   cfg_dmax = 1, cfg_hold = -1, cfg_hold_dly = 0;
    logic cfg_noise = 1'b0, cfg_early = 1'b0;
    logic cfg_valid = 1'b1, cfg_imem = 1'b0, cfg_dmem = 1'b0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int first_set(input logic [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Stages a completed instruction visits.
    task automatic add_exp(input logic [3:0] ic);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        if (ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11}) exp_q.push_back(3);
        if (!(ic inside {4'd1, 4'd4, 4'd7})) exp_q.push_back(4);
        exp_q.push_back(5);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_go%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic wait_stage(input state_e s, input int budget, input string tag);
        int n = 0;
        while (stage !== s && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, stage, s);
    endtask

    task automatic wait_go(input int idx, input int budget, input string tag);
        logic [5:0] gv;
        int n = 0;
        do begin
            tick(1);
            n++;
            gv = {pc_go, wb_go, mem_go, exec_go, decode_go, fetch_go};
        end while (!gv[idx] && n < budget);
        check(tag, gv[idx], 1'b1);
    endtask

    task automatic do_reset();
        run  = 1'b0;
        step = 1'b0;
        tick(1);
        rst_n = 1'b0;
        cfg_dmax = 1; cfg_hold = -1; cfg_hold_dly = 0;
        cfg_noise = 1'b0; cfg_early = 1'b0;
        cfg_valid = 1'b1; cfg_imem = 1'b0; cfg_dmem = 1'b0;
        tick(2);
        obs_q.delete();
        exp_q.delete();
        icq.delete();
        rsp_cycles = 0;
        rst_n = 1'b1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick(1);
        run = 1'b0;
    endtask

    // Responder: answers each go with a done after a random or configured delay.
    initial begin : responder
        int pend, since, d;
        logic [5:0] gv, dn;
        pend = -1; since = 0; d = 1;
        forever begin
            @(posedge clk);
            #1;
            dn = '0;
            icode = 4'h0; instr_valid = 1'b1; imem_error = 1'b0; dmem_error = 1'b0;
            if (!rst_n) begin
                pend = -1;
            end else begin
                int cur;
                gv = {pc_go, wb_go, mem_go, exec_go, decode_go, fetch_go};
                if (gv != 6'b0) begin
                    pend = first_set(gv);
                    since = 0;
                    obs_q.push_back(pend);
                    d = (pend == cfg_hold) ? cfg_hold_dly : int'($urandom_range(cfg_dmax, 1));
                    if (cfg_early) dn[pend] = 1'b1;
                end else if (pend >= 0) begin
                    since++;
                end
                cur = pend;
                if (pend >= 0 && since == d) begin
                    dn[pend] = 1'b1;
                    rsp_cycles += d + 1;
                    if (pend == 0) begin
                        icode       = (icq.size() > 0) ? icq.pop_front() : 4'd1;
                        instr_valid = cfg_valid;
                        imem_error  = cfg_imem;
                    end
                    if (pend == 3) dmem_error = cfg_dmem;
                    pend = -1;
                end
                if (cfg_noise)
                    for (int k = 0; k < 6; k++)
                        if (k != cur && $urandom_range(3, 0) == 0) dn[k] = 1'b1;
            end
            {pc_done, wb_done, mem_done, exec_done, decode_done, fetch_done} = dn;
        end
    end

    initial begin : time_limit
        #2000000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [3:0] ic;
        int n_obs;

        // Reset state.
        do_reset();
        check("rst_stage", stage, ST_IDLE);
        check("rst_stat", stat, STAT_AOK);
        check("rst_busy", busy, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_cycle", cycle_cnt, 0);
        check("rst_instr", instr_cnt, 0);
        check("rst_go", {pc_go, wb_go, mem_go, exec_go, decode_go, fetch_go}, 6'b0);

        // OPq with single-cycle done latency: 10 cycles, no mem stage.
        icq.push_back(4'd6);
        add_exp(4'd6);
        run = 1'b1;
        wait_go(0, 5, "opq_fetch_go");
        run = 1'b0;
        tick(9);
        check("opq_instr_pre", instr_cnt, 0);
        check("opq_stage_pre", stage, ST_PCUPD);
        tick(1);
        check("opq_instr", instr_cnt, 1);
        check("opq_idle", stage, ST_IDLE);
        check("opq_cycles", cycle_cnt, 10);
        check_seq("opq");

        // rmmovq single-stepped, with stray and go-cycle done strobes.
        do_reset();
        cfg_noise = 1'b1; cfg_early = 1'b1;
        icq.push_back(4'd4);
        add_exp(4'd4);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check("step_fetch_go", fetch_go, 1'b1);
        wait_stage(ST_IDLE, 60, "step_idle");
        check("step_busy", busy, 1'b0);
        check("step_instr", instr_cnt, 1);
        check("step_cycles", cycle_cnt, sat(rsp_cycles));
        check_seq("step");

        // run+step together acts as run: nop then halt back-to-back.
        do_reset();
        icq.push_back(4'd1); icq.push_back(4'd0);
        add_exp(4'd1); exp_q.push_back(0);
        run = 1'b1; step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_stage(ST_HALT, 60, "hlt_stage");
        check("hlt_stat", stat, STAT_HLT);
        check("hlt_instr", instr_cnt, 1);
        check("hlt_cycles", cycle_cnt, sat(rsp_cycles));
        check_seq("hlt");
        cfg_noise = 1'b1;
        n_obs = obs_q.size();
        for (int i = 0; i < 20; i++) begin
            step = 1'($urandom_range(1, 0));
            tick(1);
        end
        step = 1'b0;
        check("hlt_terminal", stage, ST_HALT);
        check("hlt_no_go", obs_q.size(), n_obs);
        check("hlt_busy", busy, 1'b0);
        check("hlt_instr_hold", instr_cnt, 1);
        do_reset();
        check("hlt_rst_stat", stat, STAT_AOK);
        check("hlt_rst_stage", stage, ST_IDLE);

        // Random back-to-back programs ending in halt.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            cfg_dmax = 4; cfg_noise = 1'b1; cfg_early = 1'b1;
            for (int i = 0; i < 12; i++) begin
                ic = 4'($urandom_range(11, 1));
                icq.push_back(ic);
                add_exp(ic);
            end
            icq.push_back(4'd0);
            exp_q.push_back(0);
            run = 1'b1;
            wait_stage(ST_HALT, 2000, $sformatf("rnd%0d_stage", r));
            run = 1'b0;
            check($sformatf("rnd%0d_instr", r), instr_cnt, 12);
            check($sformatf("rnd%0d_stat", r), stat, STAT_HLT);
            check($sformatf("rnd%0d_cycles", r), cycle_cnt, sat(rsp_cycles));
            check_seq($sformatf("rnd%0d", r));
        end

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 70; i++) icq.push_back(4'd1);
        icq.push_back(4'd0);
        run = 1'b1;
        wait_stage(ST_HALT, 2000, "sat_stage");
        run = 1'b0;
        check("sat_instr", instr_cnt, sat(70));
        check("sat_cycles", cycle_cnt, sat(rsp_cycles));

        // Fetch error priority.
        do_reset();
        cfg_imem = 1'b1; cfg_valid = 1'b0;
        icq.push_back(4'd6);
        exp_q.push_back(0);
        pulse_run();
        wait_stage(ST_HALT, 20, "adr_f_stage");
        check("adr_f_stat", stat, STAT_ADR);
        check_seq("adr_f");

        do_reset();
        cfg_valid = 1'b0;
        icq.push_back(4'd0);
        pulse_run();
        wait_stage(ST_HALT, 20, "ins_stage");
        check("ins_stat", stat, STAT_INS);
        check("ins_instr", instr_cnt, 0);

        do_reset();
        cfg_dmem = 1'b1;
        icq.push_back(4'd5);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        pulse_run();
        wait_stage(ST_HALT, 40, "adr_m_stage");
        check("adr_m_stat", stat, STAT_ADR);
        check_seq("adr_m");

        // Watchdog: exec done withheld, then done on count TIMEOUT, then TIMEOUT-1.
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cfg_hold = 2;
            cfg_hold_dly = (v == 0) ? 1000 : TIMEOUT;
            icq.push_back(4'd6);
            pulse_run();
            wait_go(2, 20, $sformatf("wd%0d_exec_go", v));
            tick(TIMEOUT);
            check($sformatf("wd%0d_pre_stage", v), stage, ST_EXEC);
            check($sformatf("wd%0d_pre_fault", v), fault, 1'b0);
            tick(1);
            check($sformatf("wd%0d_stage", v), stage, ST_FAULT);
            check($sformatf("wd%0d_fault", v), fault, 1'b1);
            check($sformatf("wd%0d_stat", v), stat, STAT_AOK);
            check($sformatf("wd%0d_busy", v), busy, 1'b0);
            tick(5);
            check($sformatf("wd%0d_sticky", v), stage, ST_FAULT);
        end
        do_reset();
        cfg_hold = 2; cfg_hold_dly = TIMEOUT - 1;
        icq.push_back(4'd6);
        add_exp(4'd6);
        pulse_run();
        wait_stage(ST_IDLE, 80, "wd_ok_idle");
        check("wd_ok_fault", fault, 1'b0);
        check("wd_ok_instr", instr_cnt, 1);
        check_seq("wd_ok");

        // Reset asserted in the exec go cycle.
        do_reset();
        cfg_hold = 2; cfg_hold_dly = 1000;
        icq.push_back(4'd6);
        pulse_run();
        wait_go(2, 20, "mid_exec_go");
        check("mid_cycles", cycle_cnt, 4);
        rst_n = 1'b0;
        #1;
        check("mid_go_drop", {pc_go, wb_go, mem_go, exec_go, decode_go, fetch_go}, 6'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_cycle_clr", cycle_cnt, 0);
        check("mid_instr_clr", instr_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("mid_idle", stage, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
